// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the bit serializer.
// State encoding, gap counter width and the bit-counter width function.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    GAP
  } state_t;

  localparam int GAP_CNT_W = 4;

  // Wide enough to hold 0..data_w inclusive.
  function automatic int bit_cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end feeding the sequence detector's X input.
// Define SERIAL_PARITY_EN to append an even-parity bit after each word.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              busy
);

  localparam int CNT_W = bit_cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST =
    (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

  state_t               state;
  logic [DATA_W-1:0]    shreg;
  logic [CNT_W-1:0]     bit_cnt;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic                 last_bit;
  logic                 accept;
`ifdef SERIAL_PARITY_EN
  logic                 par;
`endif

  // Bit that leaves the word first in the configured order.
  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
  endfunction

  // bit_cnt is the index of the bit currently on ser_bit.
  assign last_bit = (bit_cnt == LAST_IDX);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    // NOTE: default first so every path assigns in_ready and no latch is inferred.
    in_ready = 1'b0;
    if (reset_n) begin
      unique case (state)
        IDLE:    in_ready = 1'b1;
`ifdef SERIAL_PARITY_EN
        PARITY:  in_ready = (GAP_CYCLES == 0);
`else
        SHIFT:   in_ready = last_bit && (GAP_CYCLES == 0);
`endif
        default: in_ready = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      ser_bit     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      ser_bit     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;

      unique case (state)
        IDLE: ;
        SHIFT: begin
          if (!last_bit) begin
            ser_bit   <= head_bit(shreg);
            ser_valid <= 1'b1;
            shreg     <= shift_word(shreg);
            bit_cnt   <= bit_cnt + CNT_W'(1);
          end else begin
`ifdef SERIAL_PARITY_EN
            state     <= PARITY;
            ser_bit   <= par;
            ser_valid <= 1'b1;
`else
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= '0;
            end else begin
              state   <= IDLE;
            end
`endif
          end
        end
`ifdef SERIAL_PARITY_EN
        PARITY: begin
          if (GAP_CYCLES > 0) begin
            state   <= GAP;
            gap_cnt <= '0;
          end else begin
            state   <= IDLE;
          end
        end
`endif
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else gap_cnt <= gap_cnt + GAP_CNT_W'(1);
        end
        default: state <= IDLE;
      endcase

      // A handshake overrides whatever the case above chose: it is only
      // possible in IDLE or in the final cycle of a word, and the first bit
      // goes out immediately so the next cycle already carries bit 0.
      if (accept) begin
        state       <= SHIFT;
        shreg       <= shift_word(in_data);
        bit_cnt     <= '0;
        ser_bit     <= head_bit(in_data);
        ser_valid   <= 1'b1;
        frame_start <= 1'b1;
`ifdef SERIAL_PARITY_EN
        par         <= ^in_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: three configurations checked each
// cycle against a transaction-level model (accept cycle + word -> timeline).
module tb_bit_serializer;

  localparam int W  = 8;
  localparam int ND = 3;
`ifdef SERIAL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int N = W + PAR;   // valid cycles per word

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_data     [ND];
  logic         in_valid    [ND];
  logic         in_ready    [ND];
  logic         ser_bit     [ND];
  logic         ser_valid   [ND];
  logic         frame_start [ND];
  logic         busy        [ND];

  bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_d0 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ser_bit(ser_bit[0]), .ser_valid(ser_valid[0]),
    .frame_start(frame_start[0]), .busy(busy[0]));

  bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_d1 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ser_bit(ser_bit[1]), .ser_valid(ser_valid[1]),
    .frame_start(frame_start[1]), .busy(busy[1]));

  bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_d2 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .ser_bit(ser_bit[2]), .ser_valid(ser_valid[2]),
    .frame_start(frame_start[2]), .busy(busy[2]));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Model: last accepted word per DUT and the cycle it was accepted in.
  int           last_c  [ND];
  logic [W-1:0] last_w  [ND];
  int           free_at [ND];
  int           mode    [ND];   // 0 idle, 1 random, 2 directed queue
  logic [W-1:0] dir_q   [$];
  int           dir_d;

  function automatic bit msb_of(input int d);
    return d != 2;
  endfunction

  function automatic int gap_of(input int d);
    return (d == 1) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input int d, input int i);
    logic [W-1:0] w;
    w = last_w[d];
    if (i >= W) return ^w;
    return msb_of(d) ? w[W-1-i] : w[i];
  endfunction

  task automatic check_cycle();
    for (int d = 0; d < ND; d++) begin
      int i;
      bit v;
      i = t - last_c[d] - 1;
      v = (i >= 0) && (i < N);
      check($sformatf("d%0d t%0d ser_valid", d, t), ser_valid[d], v);
      check($sformatf("d%0d t%0d ser_bit", d, t), ser_bit[d], v ? exp_bit(d, i) : 1'b0);
      check($sformatf("d%0d t%0d frame_start", d, t), frame_start[d], v && (i == 0));
      check($sformatf("d%0d t%0d busy", d, t), busy[d], (i >= 0) && (i < N + gap_of(d)));
      check($sformatf("d%0d t%0d in_ready", d, t), in_ready[d], reset_n && (t >= free_at[d]));
    end
  endtask

  task automatic drive();
    for (int d = 0; d < ND; d++) begin
      in_data[d]  = W'($urandom);
      in_valid[d] = 1'b0;
      if (mode[d] == 1) begin
        in_valid[d] = ($urandom_range(0, 2) != 0);
      end else if (mode[d] == 2 && dir_d == d && dir_q.size() > 0) begin
        in_valid[d] = 1'b1;
        in_data[d]  = dir_q[0];
      end
      if (in_valid[d] && reset_n && (t >= free_at[d])) begin
        last_c[d]  = t;
        last_w[d]  = in_data[d];
        free_at[d] = t + N + ((gap_of(d) > 0) ? gap_of(d) + 1 : 0);
        if (mode[d] == 2 && dir_d == d) void'(dir_q.pop_front());
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    t++;
    check_cycle();
  endtask

  task automatic cycle();
    step();
    drive();
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s d%0d ser_valid", tag, d), ser_valid[d], 1'b0);
      check($sformatf("%s d%0d ser_bit", tag, d), ser_bit[d], 1'b0);
      check($sformatf("%s d%0d frame_start", tag, d), frame_start[d], 1'b0);
      check($sformatf("%s d%0d busy", tag, d), busy[d], 1'b0);
      check($sformatf("%s d%0d in_ready", tag, d), in_ready[d], 1'b0);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      last_c[d]  = -1000;
      free_at[d] = 0;
    end
  endtask

  initial begin
    bit found;
    reset_n = 1'b1;
    for (int d = 0; d < ND; d++) begin
      in_data[d]  = '0;
      in_valid[d] = 1'b0;
      mode[d]     = 0;
      last_w[d]   = '0;
    end
    model_reset();
    dir_d = 0;

    #1 reset_n = 1'b0;
    #1 check_reset_outputs("por");

    // First negedge is cycle 0; in_valid already high as reset releases.
    @(negedge clk);
    t = 0;
    check_cycle();
    reset_n = 1'b1;
    dir_q.push_back(8'hA5);
    mode[0] = 2;
    drive();
    repeat (12) cycle();

    // Back-to-back words on the gapless MSB-first DUT.
    dir_q.push_back(8'hFF);
    dir_q.push_back(8'h00);
    repeat (20) cycle();

    // Two queued words with a 2-cycle gap.
    mode[0] = 0;
    dir_d = 1;
    mode[1] = 2;
    dir_q.push_back(8'h96);
    dir_q.push_back(8'h5A);
    repeat (30) cycle();

    // LSB-first single word.
    mode[1] = 0;
    dir_d = 2;
    mode[2] = 2;
    dir_q.push_back(8'h01);
    repeat (12) cycle();

    // Parity-sensitive words (parity bit 1 then 0 when enabled).
    mode[2] = 0;
    dir_d = 0;
    mode[0] = 2;
    dir_q.push_back(8'h07);
    dir_q.push_back(8'h03);
    repeat (25) cycle();

    // Reset mid-word after the third bit of 8'hC3.
    dir_q.push_back(8'hC3);
    found = 1'b0;
    drive();
    for (int k = 0; k < 20; k++) begin
      step();
      if (t - last_c[0] - 1 == 2) begin
        found = 1'b1;
        break;
      end
      drive();
    end
    check("reset_wait_third_bit", found, 1'b1);
    #1 reset_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("mid_word_reset");
    step();
    reset_n = 1'b1;
    for (int d = 0; d < ND; d++) free_at[d] = t;
    dir_q.delete();
    dir_q.push_back(8'h3C);
    drive();
    repeat (12) cycle();

    // Random traffic on all three configurations.
    for (int d = 0; d < ND; d++) mode[d] = 1;
    repeat (400) cycle();

    for (int d = 0; d < ND; d++) mode[d] = 0;
    repeat (N + 6) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
